branch_predict_resolve: RTL and testbench
=========================================

Name: branch_predict_resolve

Overview:
Parametrised successor to the single-cycle jump/branch decision logic. It keeps a direction-prediction table (BHT) of saturating counters indexed by fetch PC and resolves branches and jumps in EX from ALU SUB flags. It signals a misprediction redirect and trains the table. It sits between IF (prediction lookup), EX (resolution), and PC-select/flush control, and also keeps branch and mispredict statistics.

Parameters:
XLEN, 32, PC width.
BHT_ENTRIES, 64, number of table entries; power of two, at least 2; IDX_W = log2(BHT_ENTRIES).
CTR_BITS, 2, width of each saturating counter; at least 1.
CTR_INIT, 1, counter value written by the init sweep (weakly not-taken for 2 bits).
STAT_W, 32, width of the statistics counters.

Ports:
clk  in  1  clock; all state updates on its rising edge.
rst  in  1  synchronous, active-high reset.
if_pc  in  XLEN  fetch PC for lookup.
if_predict_taken  out  1  combinational prediction for if_pc.
ready  out  1  high when the init sweep is done (RUN state).
ex_valid  in  1  EX holds a live instruction (not a bubble or flushed).
ex_pc  in  XLEN  PC of the EX instruction.
ex_branch  in  1  EX instruction is a conditional branch.
ex_jump  in  1  EX instruction is JAL or JALR.
ex_funct3  in  3  funct3 field of the EX instruction.
ex_pred_taken  in  1  prediction carried down the pipeline from IF.
zf, sf, vf, cf  in  1 each  SUB flags for rs1-rs2. cf is the carry-out of rs1+~rs2+1, so cf=0 means borrow.
should_jump  out  1  actual outcome in EX.
redirect  out  1  flush IF/ID and steer PC.
redirect_taken  out  1  when redirect is high: 1 selects the branch/jump target, 0 selects ex_pc+4.
illegal_branch  out  1  ex_branch asserted with a reserved funct3 (010 or 011).
branch_cnt  out  STAT_W  count of resolved branches.
mispred_cnt  out  STAT_W  count of branch mispredictions.

Behaviour:
- Index function: idx = pc[IDX_W+1:2], used for both lookup and update.
- State machine has two states: INIT and RUN.
- rst high: go to INIT with sweep pointer=0. branch_cnt and mispred_cnt go to 0. ready=0.
- INIT: each cycle writes CTR_INIT to entry[ptr], then ptr increments. After writing entry BHT_ENTRIES-1, move to RUN.
  - Init takes exactly BHT_ENTRIES cycles after rst deasserts.
  - ready goes high on the cycle after the final write.
- rst asserted during INIT or RUN restarts the sweep from 0 and clears the statistics.
- During INIT:
  - if_predict_taken=0.
  - Table updates and statistics updates are suppressed.
  - Resolution outputs still operate, so a pre-ready branch gets correct redirects.
- Prediction: if_predict_taken = MSB of entry[idx(if_pc)]. This is a combinational read with no bypass. A same-cycle update to the same index is seen the following cycle.
- Resolution (combinational, qualified by ex_valid; all outputs are 0 when ex_valid=0):
  - Branch outcomes by funct3:
    - 000 BEQ: taken when zf.
    - 001 BNE: taken when !zf.
    - 100 BLT: taken when sf!=vf.
    - 101 BGE: taken when sf==vf.
    - 110 BLTU: taken when !cf.
    - 111 BGEU: taken when cf.
    - 010/011: should_jump=0 and illegal_branch=1.
  - ex_branch has priority over ex_jump if both are set.
  - ex_jump only: should_jump=1, redirect=1, redirect_taken=1. ex_pred_taken is ignored because there is no target prediction.
  - Legal branch: redirect = should_jump ^ ex_pred_taken, and redirect_taken = should_jump.
  - Illegal branch: redirect = ex_pred_taken, redirect_taken=0, so fetch returns to pc+4.
  - No latches: every output is assigned on every path.
- Update, at the clock edge in RUN with ex_valid & ex_branch & legal funct3:
  - entry[idx(ex_pc)] saturating-increments if taken, otherwise saturating-decrements.
  - Counters saturate at 2^CTR_BITS-1 and at 0; there is no wrap.
  - branch_cnt increments by 1; mispred_cnt increments by 1 if redirect.
  - Both statistics counters saturate at all-ones.
  - Jumps and illegal branches do not touch the table or the statistics.
- Outputs after reset: if_predict_taken=0 and ready=0. Combinational outputs follow their inputs; they are 0 when ex_valid=0.

Decomposition:
- Shared defines/package:
  - IR_funct3 field macro.
  - Branch funct3 encodings: BEQ, BNE, BLT, BGE, BLTU, BGEU.
  - State encodings INIT and RUN.
- Sub-module bht_table holds counter storage, the init sweep pointer, the read port, and the saturating update port.
- Resolution logic and statistics stay in the top module.

Test Plan:
- Init: pulse rst, then hold rst=0 for 64 cycles -> ready=0 through cycle 63 and 1 at cycle 64. If_predict_taken=0 for every PC. Re-pulse rst at cycle 30 -> ready again needs a full 64 cycles.
- Training: BEQ at pc 0x40 with zf=1, resolved 3 times -> counter 1→2→3 and prediction for 0x40 becomes 1 after the first update. Then 2 not-taken -> 3→2→1, prediction 0. A further 2 not-taken -> stays at 0, no underflow.
- Redirect: BLTU with cf=0 and ex_pred_taken=0 -> should_jump=1, redirect=1, redirect_taken=1, mispred_cnt+1. BGE with sf=1, vf=1, ex_pred_taken=1 -> redirect=0.
- Jump/illegal: ex_jump=1 -> redirect=1, redirect_taken=1, no statistics change. ex_branch with funct3=010 and ex_pred_taken=1 -> illegal_branch=1, redirect=1, redirect_taken=0, table unchanged.
- Aliasing and same-cycle read: pcs 0x0 and 0x100 share entry 0. A taken update to 0x100 while if_pc=0x0 -> old value is seen that cycle, new value next cycle. ex_valid=0 with ex_branch=1 -> no outputs and no update.
- Saturation: force STAT_W=4 and resolve 20 branches -> branch_cnt holds at 15.

Source files
------------

// File: rtl/branch_predict_resolve_pkg.sv
// Shared encodings and the branch-condition evaluator for branch_predict_resolve.
`define IR_funct3(ir) ir[14:12]

package branch_predict_resolve_pkg;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic {ST_INIT, ST_RUN} bht_state_e;

    typedef struct packed {
        logic legal;
        logic taken;
    } br_eval_t;

    // cf is the carry-out of rs1 + ~rs2 + 1, so an unsigned less-than is !cf.
    function automatic br_eval_t br_eval(input logic [2:0] f3, input logic zf, input logic sf,
                                         input logic vf, input logic cf);
        br_eval_t r;
        r.legal = 1'b1;
        r.taken = 1'b0;
        case (f3)
            F3_BEQ:  r.taken = zf;
            F3_BNE:  r.taken = !zf;
            F3_BLT:  r.taken = sf != vf;
            F3_BGE:  r.taken = sf == vf;
            F3_BLTU: r.taken = !cf;
            F3_BGEU: r.taken = cf;
            default: r.legal = 1'b0;
        endcase
        return r;
    endfunction
endpackage

// File: rtl/branch_predict_resolve_if.sv
// IF lookup, EX resolution and statistics signals of branch_predict_resolve.
interface branch_predict_resolve_if #(
    parameter int XLEN   = 32,
    parameter int STAT_W = 32
);
    logic [XLEN-1:0]   if_pc;
    logic              if_predict_taken;
    logic              ready;
    logic              ex_valid;
    logic [XLEN-1:0]   ex_pc;
    logic              ex_branch;
    logic              ex_jump;
    logic [2:0]        ex_funct3;
    logic              ex_pred_taken;
    logic              zf, sf, vf, cf;
    logic              should_jump;
    logic              redirect;
    logic              redirect_taken;
    logic              illegal_branch;
    logic [STAT_W-1:0] branch_cnt;
    logic [STAT_W-1:0] mispred_cnt;

    modport slave (
        input  if_pc, ex_valid, ex_pc, ex_branch, ex_jump, ex_funct3, ex_pred_taken,
               zf, sf, vf, cf,
        output if_predict_taken, ready, should_jump, redirect, redirect_taken,
               illegal_branch, branch_cnt, mispred_cnt
    );

    modport master (
        output if_pc, ex_valid, ex_pc, ex_branch, ex_jump, ex_funct3, ex_pred_taken,
               zf, sf, vf, cf,
        input  if_predict_taken, ready, should_jump, redirect, redirect_taken,
               illegal_branch, branch_cnt, mispred_cnt
    );
endinterface

// File: rtl/branch_predict_resolve_bht_table.sv
// Saturating-counter direction table with a post-reset init sweep.
module bht_table
    import branch_predict_resolve_pkg::*;
#(
    parameter int BHT_ENTRIES = 64,
    parameter int CTR_BITS    = 2,
    parameter int CTR_INIT    = 1,
    localparam int IDX_W      = $clog2(BHT_ENTRIES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic             rd_taken_o,
    input  logic             upd_en_i,
    input  logic [IDX_W-1:0] upd_idx_i,
    input  logic             upd_taken_i,
    output logic             ready_o
);
    bht_state_e        state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [CTR_BITS-1:0] ctr_q [BHT_ENTRIES];
    logic [CTR_BITS-1:0] upd_cur, upd_ctr_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_INIT;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        if (state_q == ST_INIT) begin
            ptr_d = ptr_q + 1'b1;
            if (ptr_q == IDX_W'(BHT_ENTRIES - 1)) state_d = ST_RUN;
        end
    end

    assign ready_o = (state_q == ST_RUN);

    always_comb begin
        upd_cur   = ctr_q[upd_idx_i];
        upd_ctr_d = upd_cur;
        if (upd_taken_i && upd_cur != '1)       upd_ctr_d = upd_cur + 1'b1;
        else if (!upd_taken_i && upd_cur != '0) upd_ctr_d = upd_cur - 1'b1;
    end

    // Storage is not reset; the sweep rewrites every entry before RUN.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == ST_INIT)       ctr_q[ptr_q]     <= CTR_BITS'(CTR_INIT);
            else if (upd_en_i)            ctr_q[upd_idx_i] <= upd_ctr_d;
        end
    end

    assign rd_taken_o = ready_o & ctr_q[rd_idx_i][CTR_BITS-1];
endmodule

// File: rtl/branch_predict_resolve.sv
// Branch/jump resolution in EX with BHT direction prediction and branch statistics.
module branch_predict_resolve
    import branch_predict_resolve_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 64,
    parameter int CTR_BITS    = 2,
    parameter int CTR_INIT    = 1,
    parameter int STAT_W      = 32
) (
    input logic clk,
    input logic rst,
    branch_predict_resolve_if.slave bus
);
    localparam int IDX_W = $clog2(BHT_ENTRIES);

    br_eval_t          ev;
    logic              sj, redir, redir_tk, illegal, ready, upd_en;
    logic [STAT_W-1:0] branch_cnt_q, branch_cnt_d, mispred_cnt_q, mispred_cnt_d;
    logic              unused_pc;

    assign unused_pc = ^{bus.if_pc[XLEN-1:IDX_W+2], bus.if_pc[1:0],
                         bus.ex_pc[XLEN-1:IDX_W+2], bus.ex_pc[1:0]};

    bht_table #(
        .BHT_ENTRIES (BHT_ENTRIES),
        .CTR_BITS    (CTR_BITS),
        .CTR_INIT    (CTR_INIT)
    ) u_bht (
        .clk         (clk),
        .rst         (rst),
        .rd_idx_i    (bus.if_pc[IDX_W+1:2]),
        .rd_taken_o  (bus.if_predict_taken),
        .upd_en_i    (upd_en),
        .upd_idx_i   (bus.ex_pc[IDX_W+1:2]),
        .upd_taken_i (ev.taken),
        .ready_o     (ready)
    );

    // Branch wins over jump; an illegal branch falls back to pc+4.
    always_comb begin
        ev       = br_eval(bus.ex_funct3, bus.zf, bus.sf, bus.vf, bus.cf);
        sj       = 1'b0;
        redir    = 1'b0;
        redir_tk = 1'b0;
        illegal  = 1'b0;
        if (bus.ex_valid) begin
            if (bus.ex_branch) begin
                if (ev.legal) begin
                    sj       = ev.taken;
                    redir    = ev.taken ^ bus.ex_pred_taken;
                    redir_tk = ev.taken;
                end else begin
                    illegal  = 1'b1;
                    redir    = bus.ex_pred_taken;
                end
            end else if (bus.ex_jump) begin
                sj       = 1'b1;
                redir    = 1'b1;
                redir_tk = 1'b1;
            end
        end
    end

    assign upd_en = ready & bus.ex_valid & bus.ex_branch & ev.legal;

    always_comb begin
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (upd_en) begin
            if (branch_cnt_q != '1)           branch_cnt_d  = branch_cnt_q + 1'b1;
            if (redir && mispred_cnt_q != '1) mispred_cnt_d = mispred_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign bus.ready          = ready;
    assign bus.should_jump    = sj;
    assign bus.redirect       = redir;
    assign bus.redirect_taken = redir_tk;
    assign bus.illegal_branch = illegal;
    assign bus.branch_cnt     = branch_cnt_q;
    assign bus.mispred_cnt    = mispred_cnt_q;
endmodule

// File: tb/tb_branch_predict_resolve.sv
// Directed bench for branch_predict_resolve; a STAT_W=4 twin shares all inputs.
module tb_branch_predict_resolve;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    branch_predict_resolve_if #(.XLEN(32), .STAT_W(32)) bus ();
    branch_predict_resolve_if #(.XLEN(32), .STAT_W(4))  bus4 ();

    branch_predict_resolve #(.STAT_W(32)) dut  (.clk(clk), .rst(rst), .bus(bus));
    branch_predict_resolve #(.STAT_W(4))  dut4 (.clk(clk), .rst(rst), .bus(bus4));

    assign bus4.if_pc = bus.if_pc;         assign bus4.ex_valid = bus.ex_valid;
    assign bus4.ex_pc = bus.ex_pc;         assign bus4.ex_branch = bus.ex_branch;
    assign bus4.ex_jump = bus.ex_jump;     assign bus4.ex_funct3 = bus.ex_funct3;
    assign bus4.ex_pred_taken = bus.ex_pred_taken;
    assign bus4.zf = bus.zf; assign bus4.sf = bus.sf; assign bus4.vf = bus.vf; assign bus4.cf = bus.cf;

    int total = 0;
    int bad = 0;
    int exp_b, exp_m;
    int tk[9] = '{1, 1, 1, 0, 0, 0, 0, 1, 1};
    int pr[9] = '{1, 1, 1, 1, 0, 0, 0, 0, 1};

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic br, input logic jmp,
                         input logic [2:0] f3, input logic pt, input logic z, input logic s,
                         input logic o, input logic c);
        bus.ex_valid = v; bus.ex_pc = pc; bus.ex_branch = br; bus.ex_jump = jmp;
        bus.ex_funct3 = f3; bus.ex_pred_taken = pt;
        bus.zf = z; bus.sf = s; bus.vf = o; bus.cf = c;
    endtask

    task automatic idle;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset;
        rst = 1'b1; bus.if_pc = 32'h40; idle();
        tick(); tick();
        total++; if (bus.ready !== 1'b0) begin bad++; $display("FAIL rst_ready got %0b exp 0", bus.ready); end
        total++; if (bus.branch_cnt !== 32'd0) begin bad++; $display("FAIL rst_bcnt got %0d exp 0", bus.branch_cnt); end
        total++; if (bus.mispred_cnt !== 32'd0) begin bad++; $display("FAIL rst_mcnt got %0d exp 0", bus.mispred_cnt); end
        total++; if (bus.if_predict_taken !== 1'b0) begin bad++; $display("FAIL rst_pred got %0b exp 0", bus.if_predict_taken); end
        rst = 1'b0;
        for (int i = 1; i <= 64; i++) begin
            tick();
            if (i == 63) begin
                total++; if (bus.ready !== 1'b0) begin bad++; $display("FAIL init_ready63 got %0b exp 0", bus.ready); end
            end
            if (i == 64) begin
                total++; if (bus.ready !== 1'b1) begin bad++; $display("FAIL init_ready64 got %0b exp 1", bus.ready); end
            end
            if (i == 10) begin
                drive(1'b1, 32'h80, 1'b1, 1'b0, 3'b110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                #1;
                total++; if (bus.redirect !== 1'b1) begin bad++; $display("FAIL preinit_redirect got %0b exp 1", bus.redirect); end
                total++; if (bus.redirect_taken !== 1'b1) begin bad++; $display("FAIL preinit_rtaken got %0b exp 1", bus.redirect_taken); end
            end
            if (i == 11) begin
                idle();
                total++; if (bus.branch_cnt !== 32'd0) begin bad++; $display("FAIL preinit_bcnt got %0d exp 0", bus.branch_cnt); end
                total++; if (bus.mispred_cnt !== 32'd0) begin bad++; $display("FAIL preinit_mcnt got %0d exp 0", bus.mispred_cnt); end
            end
            if (i == 20) begin
                bus.if_pc = 32'h0; #1;
                total++; if (bus.if_predict_taken !== 1'b0) begin bad++; $display("FAIL init_pred got %0b exp 0", bus.if_predict_taken); end
            end
        end
    endtask

    task automatic test_init_restart;
        rst = 1'b1; tick(); rst = 1'b0;
        repeat (30) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        total++; if (bus.ready !== 1'b0) begin bad++; $display("FAIL restart_ready0 got %0b exp 0", bus.ready); end
        for (int i = 1; i <= 64; i++) begin
            tick();
            if (i == 63) begin
                total++; if (bus.ready !== 1'b0) begin bad++; $display("FAIL restart_ready63 got %0b exp 0", bus.ready); end
            end
        end
        total++; if (bus.ready !== 1'b1) begin bad++; $display("FAIL restart_ready64 got %0b exp 1", bus.ready); end
        exp_b = 0; exp_m = 0;
    endtask

    task automatic test_training;
        bus.if_pc = 32'h40; #1;
        total++; if (bus.if_predict_taken !== 1'b0) begin bad++; $display("FAIL train_pred_init got %0b exp 0", bus.if_predict_taken); end
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, 32'h40, 1'b1, 1'b0, 3'b000, 1'b0, 1'(tk[i]), 1'b0, 1'b0, 1'b1);
            #1;
            total++; if (bus.should_jump !== 1'(tk[i])) begin bad++; $display("FAIL train_sj[%0d] got %0b exp %0d", i, bus.should_jump, tk[i]); end
            tick();
            exp_b++; exp_m += tk[i];
            total++; if (bus.if_predict_taken !== 1'(pr[i])) begin bad++; $display("FAIL train_pred[%0d] got %0b exp %0d", i, bus.if_predict_taken, pr[i]); end
        end
        idle();
        total++; if (bus.branch_cnt !== 32'(exp_b)) begin bad++; $display("FAIL train_bcnt got %0d exp %0d", bus.branch_cnt, exp_b); end
        total++; if (bus.mispred_cnt !== 32'(exp_m)) begin bad++; $display("FAIL train_mcnt got %0d exp %0d", bus.mispred_cnt, exp_m); end
    endtask

    task automatic test_redirect;
        drive(1'b1, 32'h80, 1'b1, 1'b0, 3'b110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        total++; if ({bus.should_jump, bus.redirect, bus.redirect_taken} !== 3'b111) begin bad++; $display("FAIL bltu_out got %b exp 111", {bus.should_jump, bus.redirect, bus.redirect_taken}); end
        tick(); exp_b++; exp_m++;
        total++; if (bus.mispred_cnt !== 32'(exp_m)) begin bad++; $display("FAIL bltu_mcnt got %0d exp %0d", bus.mispred_cnt, exp_m); end
        drive(1'b1, 32'h84, 1'b1, 1'b0, 3'b101, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        #1;
        total++; if ({bus.should_jump, bus.redirect, bus.redirect_taken} !== 3'b101) begin bad++; $display("FAIL bge_out got %b exp 101", {bus.should_jump, bus.redirect, bus.redirect_taken}); end
        tick(); exp_b++;
        total++; if (bus.mispred_cnt !== 32'(exp_m)) begin bad++; $display("FAIL bge_mcnt got %0d exp %0d", bus.mispred_cnt, exp_m); end
        drive(1'b1, 32'h88, 1'b1, 1'b0, 3'b001, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        #1;
        total++; if ({bus.should_jump, bus.redirect, bus.redirect_taken} !== 3'b010) begin bad++; $display("FAIL bne_out got %b exp 010", {bus.should_jump, bus.redirect, bus.redirect_taken}); end
        tick(); exp_b++; exp_m++;
        idle();
        total++; if (bus.branch_cnt !== 32'(exp_b)) begin bad++; $display("FAIL redir_bcnt got %0d exp %0d", bus.branch_cnt, exp_b); end
        total++; if (bus.mispred_cnt !== 32'(exp_m)) begin bad++; $display("FAIL redir_mcnt got %0d exp %0d", bus.mispred_cnt, exp_m); end
    endtask

    task automatic test_jump_illegal;
        bus.if_pc = 32'h40;
        drive(1'b1, 32'h40, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        total++; if ({bus.should_jump, bus.redirect, bus.redirect_taken, bus.illegal_branch} !== 4'b1110) begin bad++; $display("FAIL jump_out got %b exp 1110", {bus.should_jump, bus.redirect, bus.redirect_taken, bus.illegal_branch}); end
        tick();
        drive(1'b1, 32'h40, 1'b1, 1'b0, 3'b010, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        total++; if ({bus.should_jump, bus.redirect, bus.redirect_taken, bus.illegal_branch} !== 4'b0101) begin bad++; $display("FAIL illegal_out got %b exp 0101", {bus.should_jump, bus.redirect, bus.redirect_taken, bus.illegal_branch}); end
        tick();
        idle();
        total++; if (bus.if_predict_taken !== 1'b1) begin bad++; $display("FAIL illegal_table got %0b exp 1", bus.if_predict_taken); end
        total++; if (bus.branch_cnt !== 32'(exp_b)) begin bad++; $display("FAIL jmpill_bcnt got %0d exp %0d", bus.branch_cnt, exp_b); end
        total++; if (bus.mispred_cnt !== 32'(exp_m)) begin bad++; $display("FAIL jmpill_mcnt got %0d exp %0d", bus.mispred_cnt, exp_m); end
        // Branch+jump together: branch rules apply (BEQ not taken, predicted not taken).
        drive(1'b1, 32'h40, 1'b1, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        total++; if ({bus.should_jump, bus.redirect, bus.redirect_taken} !== 3'b000) begin bad++; $display("FAIL prio_out got %b exp 000", {bus.should_jump, bus.redirect, bus.redirect_taken}); end
        tick(); exp_b++;
        idle();
        total++; if (bus.if_predict_taken !== 1'b0) begin bad++; $display("FAIL prio_table got %0b exp 0", bus.if_predict_taken); end
        total++; if (bus.branch_cnt !== 32'(exp_b)) begin bad++; $display("FAIL prio_bcnt got %0d exp %0d", bus.branch_cnt, exp_b); end
    endtask

    task automatic test_alias;
        bus.if_pc = 32'h0;
        drive(1'b1, 32'h100, 1'b1, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        #1;
        total++; if (bus.if_predict_taken !== 1'b0) begin bad++; $display("FAIL alias_same_cycle got %0b exp 0", bus.if_predict_taken); end
        tick(); exp_b++; exp_m++;
        total++; if (bus.if_predict_taken !== 1'b1) begin bad++; $display("FAIL alias_next_cycle got %0b exp 1", bus.if_predict_taken); end
        drive(1'b0, 32'h0, 1'b1, 1'b0, 3'b001, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        #1;
        total++; if ({bus.should_jump, bus.redirect, bus.redirect_taken, bus.illegal_branch} !== 4'b0000) begin bad++; $display("FAIL novalid_out got %b exp 0000", {bus.should_jump, bus.redirect, bus.redirect_taken, bus.illegal_branch}); end
        tick();
        idle();
        total++; if (bus.if_predict_taken !== 1'b1) begin bad++; $display("FAIL novalid_table got %0b exp 1", bus.if_predict_taken); end
        total++; if (bus.branch_cnt !== 32'(exp_b)) begin bad++; $display("FAIL novalid_bcnt got %0d exp %0d", bus.branch_cnt, exp_b); end
    endtask

    task automatic test_saturation;
        rst = 1'b1; tick(); rst = 1'b0;
        repeat (64) tick();
        drive(1'b1, 32'h8, 1'b1, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 14) begin
                total++; if (bus4.branch_cnt !== 4'd14) begin bad++; $display("FAIL sat_b4_14 got %0d exp 14", bus4.branch_cnt); end
            end
        end
        idle();
        total++; if (bus.branch_cnt !== 32'd20) begin bad++; $display("FAIL sat_b32 got %0d exp 20", bus.branch_cnt); end
        total++; if (bus.mispred_cnt !== 32'd20) begin bad++; $display("FAIL sat_m32 got %0d exp 20", bus.mispred_cnt); end
        total++; if (bus4.branch_cnt !== 4'd15) begin bad++; $display("FAIL sat_b4 got %0d exp 15", bus4.branch_cnt); end
        total++; if (bus4.mispred_cnt !== 4'd15) begin bad++; $display("FAIL sat_m4 got %0d exp 15", bus4.mispred_cnt); end
    endtask

    initial begin
        test_reset();
        test_init_restart();
        test_training();
        test_redirect();
        test_jump_illegal();
        test_alias();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
